// File: rtl/audio_pkg.sv
// Shared constants and types for the audio capture path.
package audio_pkg;

  localparam int DATA_SIZE   = 28;
  localparam int SAMPLE_BITS = 24;
  localparam int SEQ_BITS    = 3;

  // Field offsets inside the output word {seq, chan, sample}
  localparam int SEQ_LSB  = 25;
  localparam int CHAN_BIT = 24;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SHIFT     = 2'd1,
    EMIT      = 2'd2,
    PAD       = 2'd3
  } i2s_state_t;

endpackage

// File: rtl/i2s_rx_packer_sync_edge.sv
// Two-flop synchroniser for a strobe input plus companion inputs at identical latency,
// with a registered rising-edge pulse on the strobe.
module sync_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             edge_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             rise
);

  logic [WIDTH:0] meta_reg;
  logic [WIDTH:0] sync_reg;
  logic           prev_reg;
  logic           rise_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= '0;
      sync_reg <= '0;
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      meta_reg <= {edge_in, din};
      sync_reg <= meta_reg;
      prev_reg <= sync_reg[WIDTH];
      rise_reg <= sync_reg[WIDTH] & ~prev_reg;
    end
  end

  assign dout = sync_reg[WIDTH-1:0];
  assign rise = rise_reg;

endmodule

// File: rtl/i2s_rx_packer.sv
// I2S receiver: deserialises 24-bit samples, tags them with channel and a rolling
// sequence number, and offers them on a one-entry valid/ready output register.
module i2s_rx_packer #(
  parameter int DATA_SIZE   = audio_pkg::DATA_SIZE,
  parameter int SAMPLE_BITS = audio_pkg::SAMPLE_BITS,
  parameter int SEQ_BITS    = audio_pkg::SEQ_BITS,
  parameter int CNT_BITS    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i2s_bclk,
  input  logic                 i2s_lrclk,
  input  logic                 i2s_sdata,
  output logic                 source_valid,
  output logic [DATA_SIZE-1:0] source_data,
  input  logic                 source_ready,
  output logic [CNT_BITS-1:0]  overflow_count,
  output logic                 frame_err
);
  import audio_pkg::*;

  localparam int CW = $clog2(SAMPLE_BITS + 1);

  logic [1:0] pins_sync;
  logic       bclk_rise;
  logic       lr_sync;
  logic       sd_sync;

  sync_edge #(.WIDTH(2)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .edge_in (i2s_bclk),
    .din     ({i2s_sdata, i2s_lrclk}),
    .dout    (pins_sync),
    .rise    (bclk_rise)
  );

  assign lr_sync = pins_sync[0];
  assign sd_sync = pins_sync[1];

  logic ws_prev_reg;
  logic ws_primed_reg;
  logic ws_edge;

  // The first bclk_rise after reset only loads ws_prev, so a high lrclk at reset
  // release is not mistaken for a word boundary.
  assign ws_edge = bclk_rise & ws_primed_reg & (lr_sync != ws_prev_reg);

  i2s_state_t             state_reg, state_next;
  logic [CW-1:0]          bit_cnt_reg, bit_cnt_next;
  logic [SAMPLE_BITS-1:0] shreg_reg, shreg_next;
  logic                   chan_reg, chan_next;
  logic                   frame_err_reg, frame_err_next;

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shreg_next     = shreg_reg;
    chan_next      = chan_reg;
    frame_err_next = frame_err_reg;
    case (state_reg)
      WAIT_SYNC, PAD: begin
        if (ws_edge) begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
          chan_next    = lr_sync;
        end
      end
      SHIFT: begin
        if (ws_edge) begin
          // Short slot: drop the partial word and start over on the new channel
          frame_err_next = 1'b1;
          bit_cnt_next   = '0;
          chan_next      = lr_sync;
        end else if (bclk_rise) begin
          shreg_next   = {shreg_reg[SAMPLE_BITS-2:0], sd_sync};
          bit_cnt_next = bit_cnt_reg + CW'(1);
          if (bit_cnt_reg == CW'(SAMPLE_BITS - 1)) begin
            state_next = EMIT;
          end
        end
      end
      EMIT:    state_next = PAD;
      default: state_next = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= WAIT_SYNC;
      bit_cnt_reg   <= '0;
      shreg_reg     <= '0;
      chan_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      ws_prev_reg   <= 1'b0;
      ws_primed_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shreg_reg     <= shreg_next;
      chan_reg      <= chan_next;
      frame_err_reg <= frame_err_next;
      if (bclk_rise) begin
        ws_prev_reg   <= lr_sync;
        ws_primed_reg <= 1'b1;
      end
    end
  end

  logic                 valid_reg;
  logic [DATA_SIZE-1:0] data_reg;
  logic [SEQ_BITS-1:0]  seq_reg;
  logic [CNT_BITS-1:0]  overflow_reg;

  // An EMIT in the same cycle as an acceptance reuses the slot being freed.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg    <= 1'b0;
      data_reg     <= '0;
      seq_reg      <= '0;
      overflow_reg <= '0;
    end else if (state_reg == EMIT) begin
      seq_reg <= seq_reg + SEQ_BITS'(1);
      if (!valid_reg || source_ready) begin
        data_reg  <= {seq_reg, chan_reg, shreg_reg};
        valid_reg <= 1'b1;
      end else if (overflow_reg != '1) begin
        overflow_reg <= overflow_reg + CNT_BITS'(1);
      end
    end else if (valid_reg && source_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign source_valid   = valid_reg;
  assign source_data    = data_reg;
  assign overflow_count = overflow_reg;
  assign frame_err      = frame_err_reg;

endmodule

// File: tb/tb_i2s_rx_packer.sv
// Directed/randomised bench: drives I2S slots and checks the output stream against a slot-level model.
module tb_i2s_rx_packer;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i2s_bclk = 1'b0;
  logic        i2s_lrclk = 1'b1;
  logic        i2s_sdata = 1'b0;
  logic        source_ready = 1'b0;
  logic        source_valid;
  logic [27:0] source_data;
  logic [15:0] overflow_count;
  logic        frame_err;

  i2s_rx_packer dut (
    .clk            (clk),
    .reset          (reset),
    .i2s_bclk       (i2s_bclk),
    .i2s_lrclk      (i2s_lrclk),
    .i2s_sdata      (i2s_sdata),
    .source_valid   (source_valid),
    .source_data    (source_data),
    .source_ready   (source_ready),
    .overflow_count (overflow_count),
    .frame_err      (frame_err)
  );

  always #10 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [27:0] got_q[$];
  logic [27:0] exp_q[$];

  // Slot-level model: sequence counter, one-entry holding buffer, drop and error tallies
  logic [2:0]  m_seq = 3'd0;
  logic        m_held = 1'b0;
  logic [27:0] m_held_word = '0;
  logic        m_ready = 1'b0;
  logic        m_ferr = 1'b0;
  logic        m_short = 1'b0;
  int          m_ovf = 0;
  logic        cur_lr = 1'b1;

  always @(negedge clk) begin
    if (!reset && source_valid && source_ready) got_q.push_back(source_data);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic lr, input logic sd);
    i2s_lrclk = lr;
    i2s_sdata = sd;
    cur_lr    = lr;
    repeat (8) tick();
    i2s_bclk = 1'b1;
    repeat (8) tick();
    i2s_bclk = 1'b0;
  endtask

  task automatic model_emit(input logic c, input logic [23:0] d);
    logic [27:0] w;
    w = (28'(m_seq) << 25) | (28'(c) << 24) | 28'(d);
    m_seq = m_seq + 3'd1;
    if (m_ready) exp_q.push_back(w);
    else if (!m_held) begin
      m_held      = 1'b1;
      m_held_word = w;
    end else m_ovf++;
  endtask

  // Slot of len bclk periods: first bit is the previous word's LSB, then data MSB-first, then pad
  task automatic send_slot(input logic c, input logic [23:0] d, input int len);
    if (c != cur_lr && m_short) m_ferr = 1'b1;
    m_short = 1'b0;
    send_bit(c, 1'($urandom));
    for (int i = 1; i < len; i++) begin
      if (i <= 24) send_bit(c, d[24-i]);
      else send_bit(c, 1'($urandom));
    end
    if (len - 1 >= 24) model_emit(c, d);
    else m_short = 1'b1;
  endtask

  task automatic set_ready(input logic v);
    tick();
    source_ready = v;
    m_ready = v;
    if (v && m_held) begin
      exp_q.push_back(m_held_word);
      m_held = 1'b0;
    end
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_word"}, got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic settle();
    repeat (12) tick();
  endtask

  initial begin
    logic [27:0] last;
    // Reset with lrclk idling high (tail of a right slot)
    repeat (5) tick();
    chk("rst_valid", source_valid, 0);
    chk("rst_data", source_data, 0);
    chk("rst_ovf", overflow_count, 0);
    chk("rst_ferr", frame_err, 0);
    reset = 1'b0;
    set_ready(1'b1);
    repeat (3) send_bit(1'b1, 1'($urandom));

    // Left 0xABCDEF then right 0x123456
    send_slot(1'b0, 24'hABCDEF, 25);
    send_slot(1'b1, 24'h123456, 25);
    settle();
    chk("basic_w0_const", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'h0ABCDEF);
    check_words("basic");

    // Nine consecutive slots: sequence field wraps
    for (int i = 0; i < 9; i++) send_slot(~cur_lr, 24'($urandom), 25);
    settle();
    check_words("wrap");
    chk("wrap_ovf", overflow_count, 0);

    // Back-pressure across three slots
    set_ready(1'b0);
    send_slot(~cur_lr, 24'($urandom), 25);
    settle();
    chk("bp_valid", source_valid, 1);
    chk("bp_held", source_data, m_held_word);
    send_slot(~cur_lr, 24'($urandom), 25);
    send_slot(~cur_lr, 24'($urandom), 25);
    settle();
    chk("bp_stable", source_data, m_held_word);
    chk("bp_valid2", source_valid, 1);
    chk("bp_ovf", overflow_count, 32'(m_ovf));
    chk("bp_ovf_const", overflow_count, 2);
    last = m_held_word;
    set_ready(1'b1);
    repeat (3) tick();
    send_slot(~cur_lr, 24'($urandom), 25);
    settle();
    chk("bp_seq_jump", (got_q.size() > 0) ? 32'((got_q[$][27:25] - last[27:25]) & 3'h7) : 32'hDEAD, 3);
    check_words("bp");

    // Short slot (10 data bits) then full slots
    send_slot(~cur_lr, 24'($urandom), 11);
    send_slot(~cur_lr, 24'($urandom), 25);
    settle();
    chk("short_ferr", frame_err, m_ferr);
    check_words("short");
    send_slot(~cur_lr, 24'($urandom), 25);
    settle();
    chk("short_ferr_sticky", frame_err, 1);
    check_words("short2");

    // 32-bit slots: pad bits must never reach the sample
    for (int i = 0; i < 3; i++) send_slot(~cur_lr, 24'($urandom), 32);
    settle();
    check_words("slot32");

    // Reset mid-slot with a word pending
    set_ready(1'b0);
    send_slot(~cur_lr, 24'($urandom), 25);
    settle();
    chk("rst2_pending", source_valid, 1);
    send_slot(~cur_lr, 24'($urandom), 12);
    reset = 1'b1;
    tick();
    chk("rst2_valid", source_valid, 0);
    chk("rst2_ferr", frame_err, 0);
    chk("rst2_ovf", overflow_count, 0);
    reset = 1'b0;
    m_seq = 3'd0; m_held = 1'b0; m_ovf = 0; m_ferr = 1'b0; m_short = 1'b0;
    exp_q.delete();
    set_ready(1'b1);
    repeat (4) send_bit(cur_lr, 1'($urandom));
    send_slot(~cur_lr, 24'($urandom), 25);
    send_slot(~cur_lr, 24'($urandom), 25);
    settle();
    chk("rst2_first_seq", (got_q.size() > 0) ? 32'(got_q[0][27:25]) : 32'hDEAD, 0);
    check_words("rst2");
    chk("rst2_ferr_end", frame_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_rx_packer.md
# i2s_rx_packer

Upstream stage of the audio capture path. Deserialises a standard I2S stream from the codec (bit clock, word select, serial data) into 24-bit samples. Tags each sample with its channel and a rolling sequence number, then presents the result as a 28-bit word on a valid/ready stream. That stream feeds the bus-side FIFO bridge directly: `source_valid`/`source_data`/`source_ready` connect port-to-port.

## Interface
- `DATA_SIZE`, default 28: output word width; must equal `SAMPLE_BITS + 1 + SEQ_BITS`.
- `SAMPLE_BITS`, default 24: sample bits captured per channel slot.
- `SEQ_BITS`, default 3: width of the rolling sequence field.
- `CNT_BITS`, default 16: width of the overflow counter.

Ports:
- `clk`  in  1  system clock, 50 MHz; the only clock in the block.
- `reset`  in  1  synchronous, active-high.
- `i2s_bclk`  in  1  codec bit clock; asynchronous to `clk`.
- `i2s_lrclk`  in  1  word select; 0 = left, 1 = right; asynchronous.
- `i2s_sdata`  in  1  serial data, MSB first; asynchronous.
- `source_valid`  out  1  `source_data` holds a word.
- `source_data`  out  DATA_SIZE  `{seq[2:0], chan, sample[23:0]}` (bits 27:25, 24, 23:0).
- `source_ready`  in  1  the consumer accepts a word when both `source_valid` and `source_ready` are high.
- `overflow_count`  out  CNT_BITS  count of words dropped; saturating.
- `frame_err`  out  1  sticky; set on a short slot.

## Operation
- The three I2S inputs pass through matched 2-flop synchronisers, so their latency is identical.
- A bclk rising-edge strobe (`bclk_rise`) is derived from the synchronised bclk. All I2S sampling happens only on `bclk_rise`.
- On each `bclk_rise`, the synchronised lrclk is compared with `ws_prev`; `ws_prev` is then updated. A difference is a word-select edge (WS edge).
- FSM states and transitions:
  - `WAIT_SYNC` (reset state): ignore data. On a WS edge → `SHIFT`, with `bit_cnt`=0 and `chan`=new lrclk. The data bit on that same edge is ignored, since it is the previous word's LSB.
  - `SHIFT`: on each `bclk_rise`, shift sdata into `shreg` MSB-first and increment `bit_cnt`.
    - When `bit_cnt` reaches `SAMPLE_BITS` → `EMIT`.
    - A WS edge before `bit_cnt` reaches `SAMPLE_BITS` sets `frame_err`, discards the partial word, and restarts `SHIFT` for the new channel.
  - `EMIT` (one clk): build the word `{seq, chan, shreg}` and increment `seq`, which wraps modulo 2^SEQ_BITS. Then → `PAD`.
  - `PAD`: ignore the remaining bits in the slot. On a WS edge → `SHIFT` for the new channel.
- Output register holds one entry:
  - In `EMIT`, if the register is empty, or is being accepted in this same cycle (`source_valid && source_ready`), load the new word and assert `source_valid`.
  - Otherwise drop the new word and increment `overflow_count`, which saturates at all-ones. `seq` still increments, so the consumer sees a gap.
  - `source_valid` stays high and `source_data` stays stable until accepted.
- `frame_err` clears only on reset.

## Timing
- Reset values: `source_valid`=0, `source_data`=0, `overflow_count`=0, `frame_err`=0, `seq`=0, state=`WAIT_SYNC`, synchroniser flops=0.
- `bclk_rise` strobe is 3 clk after the actual pin edge: 2 synchroniser flops plus 1 edge register.
- `EMIT` occurs 1 clk after the `bclk_rise` that captures the LSB. `source_valid` rises 1 clk after `EMIT`.
- Requirement: `clk` ≥ 8× bclk. At 48 kHz × 64 (bclk = 3.072 MHz) there are about 16 clk per bit.
- Simultaneous `EMIT` and acceptance counts as not full: the new word loads with no drop.
- Reset asserted mid-slot discards the partial sample and any held output word, then the FSM resynchronises on the next WS edge.

## Structure
- Package `audio_pkg` holds:
  - the `DATA_SIZE`/`SAMPLE_BITS`/`SEQ_BITS` constants;
  - the field offsets `SEQ_LSB`=25 and `CHAN_BIT`=24;
  - the `i2s_state_t` enum (`WAIT_SYNC`, `SHIFT`, `EMIT`, `PAD`).
- Sub-module `sync_edge`: 2-flop synchroniser with a registered rising-edge output, instantiated for bclk. lrclk and sdata use its plain synchronised output without the edge detector.
- Top-level RTL is 150–250 lines.

## Test plan
- Reset, then one left slot with sample 0xABCDEF followed by a right slot with 0x123456, `source_ready`=1 → words 0x0ABCDEF (seq 0, chan 0) and 0x3123456 (seq 1, chan 1).
- Nine consecutive slots, ready held high → seq fields 0..7, then 0 again (wrap); `overflow_count`=0.
- `source_ready`=0 across three completed slots → first word held stable, two drops, `overflow_count`=2. On release, the held word is accepted and the next emitted word shows a seq jump of 3.
- WS edge after only 10 bits in a slot → `frame_err`=1, no word emitted for that slot, next full slot emits normally, `frame_err` remains 1.
- 32-bit slots (24 data bits + 8 pad bits) → only the upper 24 bits are captured; pad bits never appear.
- `reset` pulsed mid-slot with a word pending → `source_valid`=0 next clk, seq restarts at 0, first word after reset comes from the first full slot following a WS edge.
